// File: rtl/clink_cell_update.sv
// LSTM cell/hidden-state update downstream of the Clink REC controller:
// captures I/G/F/O gates, computes c = f*c + i*g, then h = o*tanh(c).
module clink_cell_update #(
  parameter int DW   = 16,
  parameter int FRAC = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [2:0]           curr_s,
  input  logic [2:0]           iter_n,
  input  logic signed [DW-1:0] gate_data,
  input  logic                 gate_valid,
  input  logic signed [DW-1:0] tanh_data,
  input  logic                 tanh_valid,
  output logic signed [DW-1:0] c_out,
  output logic                 c_valid,
  output logic signed [DW-1:0] h_out,
  output logic                 h_valid,
  output logic [2:0]           h_idx,
  output logic                 busy,
  output logic                 proto_err
);

  typedef enum logic [1:0] {S_CAPT, S_MUL, S_WAIT_T} state_t;

  localparam logic signed [2*DW:0] SMAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] SMIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  state_t state, state_nx;

  logic [2:0]             prev_s;
  logic signed [DW-1:0]   i_r, g_r, f_r, o_r, c_reg;
  logic signed [2*DW-1:0] p_fc, p_ig, h_prod;
  logic signed [DW-1:0]   c_next, h_next;
  logic entry, start, do_c, do_h, capt, err;

  // Arithmetic shift floors toward -inf, then clamp into DW bits.
  function automatic logic signed [DW-1:0] sat(input logic signed [2*DW:0] v);
    logic signed [2*DW:0] s;
    s = v >>> FRAC;
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    return s[DW-1:0];
  endfunction

  assign entry  = (curr_s == 3'd5) && (prev_s != 3'd5);
  assign h_prod = o_r * tanh_data;
  assign c_next = sat({p_fc[2*DW-1], p_fc} + {p_ig[2*DW-1], p_ig});
  assign h_next = sat({h_prod[2*DW-1], h_prod});

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_CAPT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CAPT:   if (entry) state_nx = S_MUL;
      S_MUL:    state_nx = S_WAIT_T;
      S_WAIT_T: if (tanh_valid) state_nx = S_CAPT;
      default:  state_nx = S_CAPT;
    endcase
  end

  always_comb begin
    capt  = (state == S_CAPT);
    start = capt && entry;
    do_c  = (state == S_MUL);
    do_h  = (state == S_WAIT_T) && tanh_valid;
    err   = (gate_valid && (curr_s == 3'd0 || curr_s >= 3'd5))
          || (tanh_valid && state != S_WAIT_T)
          || (entry && !capt);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_s    <= '0;
      i_r       <= '0;
      g_r       <= '0;
      f_r       <= '0;
      o_r       <= '0;
      c_reg     <= '0;
      p_fc      <= '0;
      p_ig      <= '0;
      c_out     <= '0;
      c_valid   <= 1'b0;
      h_out     <= '0;
      h_valid   <= 1'b0;
      h_idx     <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      prev_s  <= curr_s;
      c_valid <= do_c;
      h_valid <= do_h;
      // Gates are frozen outside S_CAPT so in-flight work uses latched operands.
      if (capt) begin
        if (curr_s == 3'd0) begin
          i_r   <= '0;
          g_r   <= '0;
          f_r   <= '0;
          o_r   <= '0;
          c_reg <= '0;
        end else if (gate_valid) begin
          case (curr_s)
            3'd1:    i_r <= gate_data;
            3'd2:    g_r <= gate_data;
            3'd3:    f_r <= gate_data;
            3'd4:    o_r <= gate_data;
            default: ;
          endcase
        end
      end
      if (start) begin
        p_fc  <= f_r * c_reg;
        p_ig  <= i_r * g_r;
        h_idx <= iter_n;
        busy  <= 1'b1;
      end
      if (do_c) begin
        c_reg <= c_next;
        c_out <= c_next;
      end
      if (do_h) begin
        h_out <= h_next;
        busy  <= 1'b0;
      end
      if (err) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clink_cell_update.sv
// Scoreboard bench for clink_cell_update: directed iterations push expected
// c/h results; a negedge monitor pops and compares on c_valid/h_valid.
module tb_clink_cell_update;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [2:0]         curr_s, iter_n;
  logic signed [15:0] gate_data, tanh_data;
  logic               gate_valid, tanh_valid;
  logic signed [15:0] c_out, h_out;
  logic               c_valid, h_valid, busy, proto_err;
  logic [2:0]         h_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cq[$];
  int hq[$];
  int iq[$];

  clink_cell_update #(.DW(16), .FRAC(12)) dut (
    .clock(clock), .reset_n(reset_n), .curr_s(curr_s), .iter_n(iter_n),
    .gate_data(gate_data), .gate_valid(gate_valid),
    .tanh_data(tanh_data), .tanh_valid(tanh_valid),
    .c_out(c_out), .c_valid(c_valid), .h_out(h_out), .h_valid(h_valid),
    .h_idx(h_idx), .busy(busy), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (c_valid) begin
      if (cq.size() == 0) chk("c_valid_unexpected", 1, 0);
      else chk("c_out", int'(c_out), cq.pop_front());
    end
    if (h_valid) begin
      if (hq.size() == 0) chk("h_valid_unexpected", 1, 0);
      else begin
        chk("h_out", int'(h_out), hq.pop_front());
        chk("h_idx", int'(h_idx), iq.pop_front());
      end
    end
  end

  task automatic drive(input int s, input int it, input bit gv, input int gd,
                       input bit tv, input int td);
    @(negedge clock);
    curr_s     = 3'(s);
    iter_n     = 3'(it);
    gate_valid = gv;
    gate_data  = 16'(gd);
    tanh_valid = tv;
    tanh_data  = 16'(td);
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic run_iter(input int it, input int i, input int g, input int f,
                          input int o, input int td, input int dly,
                          input int ec, input int eh);
    drive(1, it, 1, i, 0, 0);
    drive(2, it, 1, g, 0, 0);
    drive(3, it, 1, f, 0, 0);
    drive(4, it, 1, o, 0, 0);
    cq.push_back(ec);
    hq.push_back(eh);
    iq.push_back(it);
    drive(5, it, 0, 0, 0, 0);
    drive(5, it, 0, 0, 0, 0);
    after_edge();
    chk("busy_after_c", int'(busy), 1);
    for (int k = 0; k < dly; k++) begin
      drive(5, it, 0, 0, 0, 0);
      after_edge();
      chk("busy_waiting_tanh", int'(busy), 1);
    end
    drive(5, it, 0, 0, 1, td);
    after_edge();
    chk("busy_after_h", int'(busy), 0);
    drive(5, it, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1, 0, 1, 100, 0, 0);
    drive(6, 0, 0, 0, 1, 50);
    after_edge();
    chk("rst_c_out", int'(c_out), 0);
    chk("rst_c_valid", int'(c_valid), 0);
    chk("rst_h_out", int'(h_out), 0);
    chk("rst_h_valid", int'(h_valid), 0);
    chk("rst_h_idx", int'(h_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Basic iteration, then a second one chained with no IDLE between.
    run_iter(0, 2048, 4096, 2048, 4096, 1893, 0, 2048, 1893);
    run_iter(1, 4096, 4096, 4096, 2048, 3000, 0, 6144, 1500);

    // Positive saturation of c and h.
    drive(0, 0, 0, 0, 0, 0);
    run_iter(2, 4096, 28672, 0, 4096, 100, 0, 28672, 100);
    run_iter(3, 4096, 4096, 4096, 32767, 32767, 0, 32767, 32767);

    // Negative side, including floor truncation and clamping.
    drive(0, 0, 0, 0, 0, 0);
    run_iter(4, 4096, -28672, 0, 3, -1, 0, -28672, -1);
    run_iter(5, 4096, -4096, 4096, 4096, -2000, 0, -32768, -2000);
    run_iter(6, 4096, -8192, 4096, -32768, 32767, 0, -32768, -32768);

    // Late tanh, then a stray tanh_valid outside the wait state.
    run_iter(7, 0, 0, 4096, 4096, 500, 5, -32768, 500);
    chk("proto_err_clean", int'(proto_err), 0);
    drive(1, 0, 0, 0, 1, 999);
    drive(1, 0, 0, 0, 0, 0);
    after_edge();
    chk("proto_err_stray_tanh", int'(proto_err), 1);
    chk("h_out_held", int'(h_out), 500);

    // Reset clears proto_err; gate_valid in FINISH sets it.
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    after_edge();
    chk("proto_err_after_reset", int'(proto_err), 0);
    run_iter(1, 4096, 4096, 0, 4096, 10, 0, 4096, 10);
    drive(6, 0, 1, 1234, 0, 0);
    drive(6, 0, 0, 0, 0, 0);
    after_edge();
    chk("proto_err_gate_finish", int'(proto_err), 1);

    // IDLE clears c, so f*c contributes nothing.
    drive(0, 0, 0, 0, 0, 0);
    run_iter(2, 0, 0, 4096, 4096, 0, 0, 0, 0);

    // Reset at E+1 must suppress the pending c/h.
    drive(1, 3, 1, 4096, 0, 0);
    drive(2, 3, 1, 4096, 0, 0);
    drive(3, 3, 1, 4096, 0, 0);
    drive(4, 3, 1, 4096, 0, 0);
    drive(5, 3, 0, 0, 0, 0);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("busy_after_mid_reset", int'(busy), 0);
    chk("c_out_after_mid_reset", int'(c_out), 0);

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("pending_c_left", cq.size(), 0);
    chk("pending_h_left", hq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
